// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit.
// Access size codes and the FSM state enum.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE,
        RESP
    } state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Lane steering for the load/store unit (combinational).
// Ports: rdata/wdata/lane/size/sign in; ext (extended load), merged (RMW word) out.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] ext,
    output logic [31:0] merged
);

    logic [7:0]  b;
    logic [15:0] h;

    assign b = rdata[{lane, 3'b000} +: 8];
    assign h = rdata[{lane[1], 4'b0000} +: 16];

    always_comb begin
        ext    = rdata;
        merged = wdata;
        unique case (size)
            SZ_BYTE: begin
                ext    = {{24{sign & b[7]}}, b};
                merged = rdata;
                merged[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                ext    = {{16{sign & h[15]}}, h};
                merged = rdata;
                merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                ext    = rdata;
                merged = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute stage and a dual-port RAM.
// Ports: m_clock, p_reset; req_* handshake in; rsp_* handshake out; mem_* to dpram.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 4096
) (
    input  logic        m_clock,
    input  logic        p_reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr_r,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr_w,
    output logic [31:0] mem_wdata,
    output logic        mem_we
);

    state_t      state, nxt;
    logic [31:0] r_base;
    logic [1:0]  r_lane;
    logic [1:0]  r_size;
    logic        r_sign;
    logic [31:0] wbuf;
    logic [31:0] ext, merged;
    logic [31:0] base;
    logic        dec_err;
    logic        acc;

    assign base = {req_addr[31:2], 2'b00};
    assign acc  = req_valid & req_ready;

    // Range check done in 33 bits so the top word cannot wrap to a legal address.
    assign dec_err = (req_size == 2'd3)
                   | ((req_size == SZ_HALF) & req_addr[0])
                   | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00))
                   | (({1'b0, base} + 33'd4) > 33'(MEM_BYTES));

    lsu_lane_align u_align (
        .rdata  (mem_rdata),
        .wdata  (wbuf),
        .lane   (r_lane),
        .size   (r_size),
        .sign   (r_sign),
        .ext    (ext),
        .merged (merged)
    );

    assign mem_addr_w = r_base;
    assign mem_wdata  = wbuf;

    always_comb begin
        nxt        = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        mem_we     = 1'b0;
        mem_addr_r = '0;
        unique case (state)
            IDLE: begin
                req_ready = ~p_reset;
                if (req_valid) begin
                    if (dec_err)                nxt = RESP;
                    else if (!req_we)           nxt = LOAD;
                    else if (req_size == SZ_WORD) nxt = WRITE;
                    else                        nxt = RMW_RD;
                end
            end
            LOAD: begin
                mem_addr_r = r_base;
                nxt        = RESP;
            end
            RMW_RD: begin
                mem_addr_r = r_base;
                nxt        = WRITE;
            end
            WRITE: begin
                // Gated so a reset during WRITE never reaches the RAM.
                mem_we = ~p_reset;
                nxt    = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            state     <= IDLE;
            r_base    <= '0;
            r_lane    <= '0;
            r_size    <= '0;
            r_sign    <= 1'b0;
            wbuf      <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= nxt;
            if (acc) begin
                r_base    <= base;
                r_lane    <= req_addr[1:0];
                r_size    <= req_size;
                r_sign    <= req_signed;
                rsp_rdata <= '0;
                rsp_err   <= dec_err;
                if (req_we) wbuf <= req_wdata;
            end
            if (state == LOAD)   rsp_rdata <= ext;
            if (state == RMW_RD) wbuf      <= merged;
        end
    end

endmodule
